// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-through bypass at capture, load-use
// stall detection, bubble insertion on stall/flush, EX-stage operand
// forwarding from EX/MEM and MEM/WB, and stall/flush event counters.
module id_ex_stage #(
    parameter int bit_width = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic [4:0]           id_rd,
    input  logic [bit_width-1:0] id_rd_data1,
    input  logic [bit_width-1:0] id_rd_data2,
    input  logic [bit_width-1:0] id_imm,
    input  logic [bit_width-1:0] id_pc,
    input  logic                 id_reg_wr,
    input  logic                 id_mem_rd,
    input  logic                 id_mem_wr,
    input  logic                 id_alu_src,
    input  logic [3:0]           id_alu_op,
    input  logic                 flush,
    input  logic                 exm_reg_wr,
    input  logic [4:0]           exm_rd,
    input  logic [bit_width-1:0] exm_result,
    input  logic                 wb_reg_wr,
    input  logic [4:0]           wb_rd,
    input  logic [bit_width-1:0] wb_data,
    output logic                 stall,
    output logic                 ex_valid,
    output logic                 ex_reg_wr,
    output logic                 ex_mem_rd,
    output logic                 ex_mem_wr,
    output logic                 ex_alu_src,
    output logic [3:0]           ex_alu_op,
    output logic [4:0]           ex_rs,
    output logic [4:0]           ex_rt,
    output logic [4:0]           ex_rd,
    output logic [bit_width-1:0] ex_imm,
    output logic [bit_width-1:0] ex_pc,
    output logic [bit_width-1:0] ex_op_a,
    output logic [bit_width-1:0] ex_op_b,
    output logic [31:0]          stall_count,
    output logic [31:0]          flush_count
);

    // Operand values as captured into ID/EX, before EX forwarding.
    logic [bit_width-1:0] rs_val_p1;
    logic [bit_width-1:0] rt_val_p1;

    // Register-file read data is stale while the same register is being
    // written back this cycle, so take the write-back data instead.
    // Register 0 is never bypassed.
    function automatic logic [bit_width-1:0] bypass(
        input logic                 wr_en,
        input logic [4:0]           wr_idx,
        input logic [4:0]           rd_idx,
        input logic [bit_width-1:0] wr_val,
        input logic [bit_width-1:0] rd_val
    );
        if (wr_en && (wr_idx != 5'd0) && (wr_idx == rd_idx))
            return wr_val;
        return rd_val;
    endfunction

    // EX/MEM is younger than MEM/WB and therefore wins when both target
    // the same register.
    function automatic logic [bit_width-1:0] forward(
        input logic [4:0]           src_idx,
        input logic [bit_width-1:0] cap_val,
        input logic                 m_wr,
        input logic [4:0]           m_idx,
        input logic [bit_width-1:0] m_val,
        input logic                 w_wr,
        input logic [4:0]           w_idx,
        input logic [bit_width-1:0] w_val
    );
        if (m_wr && (m_idx != 5'd0) && (m_idx == src_idx))
            return m_val;
        if (w_wr && (w_idx != 5'd0) && (w_idx == src_idx))
            return w_val;
        return cap_val;
    endfunction

    // Load-use hazard: a load in EX whose destination is read in decode.
    // rt is compared even for I-format instructions; over-stalling is safe.
    always_comb begin
        stall = id_valid & ex_valid & ex_mem_rd & (ex_rd != 5'd0) &
                ((ex_rd == id_rs) | (ex_rd == id_rt));
    end

    // ID/EX register: bubble on flush or stall, else capture decode fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_reg_wr  <= 1'b0;
            ex_mem_rd  <= 1'b0;
            ex_mem_wr  <= 1'b0;
            ex_alu_src <= 1'b0;
            ex_alu_op  <= 4'd0;
            ex_rs      <= 5'd0;
            ex_rt      <= 5'd0;
            ex_rd      <= 5'd0;
            ex_imm     <= '0;
            ex_pc      <= '0;
            rs_val_p1  <= '0;
            rt_val_p1  <= '0;
        end else if (flush || stall) begin
            // Bubble: controls and indices cleared, imm/pc held.
            ex_valid   <= 1'b0;
            ex_reg_wr  <= 1'b0;
            ex_mem_rd  <= 1'b0;
            ex_mem_wr  <= 1'b0;
            ex_alu_src <= 1'b0;
            ex_alu_op  <= 4'd0;
            ex_rs      <= 5'd0;
            ex_rt      <= 5'd0;
            ex_rd      <= 5'd0;
            rs_val_p1  <= '0;
            rt_val_p1  <= '0;
        end else begin
            ex_valid   <= id_valid;
            ex_reg_wr  <= id_reg_wr;
            ex_mem_rd  <= id_mem_rd;
            ex_mem_wr  <= id_mem_wr;
            ex_alu_src <= id_alu_src;
            ex_alu_op  <= id_alu_op;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_imm     <= id_imm;
            ex_pc      <= id_pc;
            rs_val_p1  <= bypass(wb_reg_wr, wb_rd, id_rs, wb_data, id_rd_data1);
            rt_val_p1  <= bypass(wb_reg_wr, wb_rd, id_rt, wb_data, id_rd_data2);
        end
    end

    // EX operands after forwarding from the later pipeline stages.
    always_comb begin
        ex_op_a = forward(ex_rs, rs_val_p1, exm_reg_wr, exm_rd, exm_result,
                          wb_reg_wr, wb_rd, wb_data);
        ex_op_b = forward(ex_rt, rt_val_p1, exm_reg_wr, exm_rd, exm_result,
                          wb_reg_wr, wb_rd, wb_data);
    end

    // Event counters; a stall masked by a flush is counted only as a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (stall && !flush)
                stall_count <= stall_count + 32'd1;
            if (flush)
                flush_count <= flush_count + 32'd1;
        end
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the 5-stage CPU. It captures the two register-file read operands, the immediate and the decoded control word into the ID/EX register. It detects load-use hazards and raises a stall, inserts bubbles on stall or flush, and presents EX-stage operands after EX/MEM and MEM/WB forwarding. It also keeps stall and flush event counters for the simulation report.

## Interface
Parameters:
- bit_width, 32, datapath width for operands, immediate and PC.

Ports (clock and reset first):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs, id_rt  in  5  source register indices, also driven to the register file read ports.
- id_rd  in  5  destination index.
- id_rd_data1, id_rd_data2  in  bit_width  register file read data for rs and rt.
- id_imm, id_pc  in  bit_width  sign-extended immediate and instruction PC.
- id_reg_wr, id_mem_rd, id_mem_wr, id_alu_src  in  1  decoded controls.
- id_alu_op  in  4  ALU operation code.
- flush  in  1  branch/jump taken in EX; kill the instruction in decode.
- exm_reg_wr  in  1  EX/MEM instruction writes a register.
- exm_rd  in  5  EX/MEM destination index.
- exm_result  in  bit_width  EX/MEM ALU result.
- wb_reg_wr  in  1  MEM/WB instruction writes a register; same signal as the register file write enable.
- wb_rd  in  5  MEM/WB destination index.
- wb_data  in  bit_width  MEM/WB write-back data.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_alu_src  out  1  registered control bits.
- ex_alu_op  out  4  registered ALU operation code.
- ex_rs, ex_rt, ex_rd  out  5  registered register indices.
- ex_imm, ex_pc  out  bit_width  registered immediate and PC.
- ex_op_a, ex_op_b  out  bit_width  forwarded EX operands, combinational.
- stall_count, flush_count  out  32  event counters.

## Operation
- Write-through bypass at capture:
  - The register file commits writes at the clock edge, so its read data is stale during a same-cycle write.
  - Captured rs value = wb_data if wb_reg_wr and wb_rd != 0 and wb_rd == id_rs; otherwise id_rd_data1.
  - The rt value is captured the same way.
- Load-use stall: stall = id_valid & ex_valid & ex_mem_rd & ex_rd != 0 & (ex_rd == id_rs | ex_rd == id_rt).
  - rt is compared regardless of instruction format; a conservative stall is acceptable.
- Register update at each rising edge, in priority order:
  1. flush: load a bubble. flush wins over stall.
  2. stall: load a bubble. The decode instruction is held upstream and re-presented next cycle.
  3. Otherwise: capture all id_* fields, with ex_valid = id_valid.
- Bubble contents: ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_alu_src = 0; ex_alu_op = 0; ex_rs, ex_rt, ex_rd = 0. ex_imm and ex_pc are held.
- EX forwarding for ex_op_a from the captured rs value, in priority order:
  1. exm_reg_wr & exm_rd != 0 & exm_rd == ex_rs → exm_result.
  2. wb_reg_wr & wb_rd != 0 & wb_rd == ex_rs → wb_data.
  3. Otherwise the captured value.
- ex_op_b is formed the same way using ex_rt.
- Register 0 is never forwarded or bypassed, so reads of register 0 return 0.
- Counters:
  - stall_count increments on each edge where stall & !flush.
  - flush_count increments on each edge where flush.
  - Both wrap modulo 2^32.

## Timing
- rst asserted: all ex_* registers, stall_count and flush_count clear to 0 immediately. ex_op_a and ex_op_b then read 0 unless forwarding matches.
- rst mid-operation: the instruction in flight is discarded. No partial state survives.
- Latency: an ID-to-EX field appears one clock after capture.
- stall is combinational on the current id_* inputs and the ID/EX register. It asserts in the same cycle the dependent instruction sits in decode.
- A load-use pair costs exactly one stall cycle. The next cycle the load is in EX/MEM, the load result is forwarded through MEM/WB, and no further stall occurs.
- flush and stall in the same cycle: a bubble is loaded, flush_count increments, stall_count does not.
- EX/MEM and MEM/WB targeting the same register: the EX/MEM value wins.

## Test plan
- Reset: assert rst mid-stream with ex_valid=1 → all ex_* outputs and both counters read 0 before the next edge. Outputs stay 0 until the first capture after release.
- Plain capture: id_rs=3 with data1=0x11, id_rt=4 with data2=0x22, imm=0xFFFFFFF0, no hazards → next cycle ex_op_a=0x11, ex_op_b=0x22, ex_imm=0xFFFFFFF0, ex_valid=1.
- Load-use: a load to r5 in EX, and id_rs=5 in decode → stall=1 for exactly one cycle and a bubble enters EX (ex_valid=0, ex_reg_wr=0). Next cycle set wb_rd=5, wb_data=0xABCD → the dependent instruction gets ex_op_a=0xABCD. stall_count=1.
- Forward priority: ex_rs=7 with exm_rd=7/exm_result=0x1 and wb_rd=7/wb_data=0x2 → ex_op_a=0x1. Drop exm_reg_wr → 0x2.
- Register 0 and write-through:
  - id_rs=0 with exm_rd=0 and exm_reg_wr=1 → ex_op_a=0.
  - wb_rd=9, wb_data=0x55 written in the same cycle as id_rt=9 with stale data2=0x0 → captured ex_op_b=0x55.
- Flush vs stall: flush=1 while a load-use stall is pending → bubble loaded, flush_count=1, stall_count unchanged.
